// File: rtl/stg_ma.sv
// Memory-access stage: non-memory ops pass through with 1 cycle latency; loads/stores
// run a req/ack transaction on the data port, stalling upstream until ack or timeout.
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 1
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 1
`endif

module stg_ma #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic [47:0]            iw_pc,
  input  logic [23:0]            iw_instr,
  input  logic [`HBIT_OPC:0]     iw_opc,
  input  logic                   iw_mem_rd,
  input  logic                   iw_mem_wr,
  input  logic [47:0]            iw_addr,
  input  logic [23:0]            iw_result,
  input  logic [47:0]            iw_ar_result,
  input  logic [47:0]            iw_sr_result,
  input  logic [`HBIT_TGT_GP:0]  iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [`HBIT_TGT_AR:0]  iw_tgt_ar,
  input  logic                   iw_tgt_ar_we,
  input  logic [`HBIT_TGT_SR:0]  iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic                   iw_flush,
  input  logic                   iw_stall,
  output logic                   ow_mem_req,
  output logic                   ow_mem_we,
  output logic [47:0]            ow_mem_addr,
  output logic [23:0]            ow_mem_wdata,
  input  logic                   iw_mem_ack,
  input  logic [23:0]            iw_mem_rdata,
  output logic [47:0]            ow_pc,
  output logic [23:0]            ow_instr,
  output logic [`HBIT_OPC:0]     ow_opc,
  output logic [23:0]            ow_result,
  output logic [47:0]            ow_ar_result,
  output logic [47:0]            ow_sr_result,
  output logic [`HBIT_TGT_GP:0]  ow_tgt_gp,
  output logic                   ow_tgt_gp_we,
  output logic [`HBIT_TGT_AR:0]  ow_tgt_ar,
  output logic                   ow_tgt_ar_we,
  output logic [`HBIT_TGT_SR:0]  ow_tgt_sr,
  output logic                   ow_tgt_sr_we,
  output logic                   ow_stall,
  output logic                   ow_fault
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [47:0]           pc;
    logic [23:0]           instr;
    logic [`HBIT_OPC:0]    opc;
    logic [23:0]           result;
    logic [47:0]           ar_result;
    logic [47:0]           sr_result;
    logic [`HBIT_TGT_GP:0] tgt_gp;
    logic                  tgt_gp_we;
    logic [`HBIT_TGT_AR:0] tgt_ar;
    logic                  tgt_ar_we;
    logic [`HBIT_TGT_SR:0] tgt_sr;
    logic                  tgt_sr_we;
  } stage_t;

  function automatic stage_t bubble(input stage_t s);
    stage_t b;
    b           = s;
    b.tgt_gp_we = 1'b0;
    b.tgt_ar_we = 1'b0;
    b.tgt_sr_we = 1'b0;
    return b;
  endfunction

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  stage_t          in_s;
  stage_t          lat_q, lat_d;
  stage_t          out_q, out_d;
  logic [47:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic            flushed_q, flushed_d;
  logic            fault_q, fault_d;

  assign in_s = '{
    pc:        iw_pc,
    instr:     iw_instr,
    opc:       iw_opc,
    result:    iw_result,
    ar_result: iw_ar_result,
    sr_result: iw_sr_result,
    tgt_gp:    iw_tgt_gp,
    tgt_gp_we: iw_tgt_gp_we,
    tgt_ar:    iw_tgt_ar,
    tgt_ar_we: iw_tgt_ar_we,
    tgt_sr:    iw_tgt_sr,
    tgt_sr_we: iw_tgt_sr_we
  };

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    out_d     = out_q;
    addr_d    = addr_q;
    we_d      = we_q;
    flushed_d = flushed_q;
    fault_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iw_flush) begin
          out_d = bubble(in_s);
        end else if (!iw_stall) begin
          if (iw_mem_rd || iw_mem_wr) begin
            state_d   = S_WAIT;
            cnt_d     = '0;
            lat_d     = in_s;
            addr_d    = iw_addr;
            we_d      = iw_mem_wr;
            flushed_d = 1'b0;
            out_d     = bubble(in_s);
          end else begin
            out_d = in_s;
          end
        end
      end
      S_WAIT: begin
        // A flush cannot abort the bus cycle; it only squashes the eventual writeback.
        if (iw_flush) flushed_d = 1'b1;
        // Completion overrides iw_stall: the one-cycle ack cannot be deferred.
        if (iw_mem_ack) begin
          out_d = lat_q;
          if (!we_q) out_d.result = iw_mem_rdata;
          if (we_q || flushed_q || iw_flush) out_d = bubble(out_d);
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          out_d   = bubble(lat_q);
          fault_d = !(flushed_q || iw_flush);
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      out_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      flushed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      out_q     <= out_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      flushed_q <= flushed_d;
      fault_q   <= fault_d;
    end
  end

  assign ow_mem_req   = (state_q == S_WAIT);
  assign ow_mem_we    = we_q;
  assign ow_mem_addr  = addr_q;
  assign ow_mem_wdata = lat_q.result;
  assign ow_stall     = (state_q == S_WAIT) && !iw_mem_ack;
  assign ow_fault     = fault_q;

  assign ow_pc        = out_q.pc;
  assign ow_instr     = out_q.instr;
  assign ow_opc       = out_q.opc;
  assign ow_result    = out_q.result;
  assign ow_ar_result = out_q.ar_result;
  assign ow_sr_result = out_q.sr_result;
  assign ow_tgt_gp    = out_q.tgt_gp;
  assign ow_tgt_gp_we = out_q.tgt_gp_we;
  assign ow_tgt_ar    = out_q.tgt_ar;
  assign ow_tgt_ar_we = out_q.tgt_ar_we;
  assign ow_tgt_sr    = out_q.tgt_sr;
  assign ow_tgt_sr_we = out_q.tgt_sr_we;

endmodule

// File: tb/tb_stg_ma.sv
// Directed-vector bench for stg_ma: pass-through, load/store, back-to-back, timeout, flush, reset.
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 1
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 1
`endif

module tb_stg_ma;
  localparam logic [`HBIT_OPC:0] OPC_CSRRD = 8'h21;

  logic                  iw_clk = 1'b0;
  logic                  iw_rst;
  logic [47:0]           iw_pc;
  logic [23:0]           iw_instr;
  logic [`HBIT_OPC:0]    iw_opc;
  logic                  iw_mem_rd, iw_mem_wr;
  logic [47:0]           iw_addr;
  logic [23:0]           iw_result;
  logic [47:0]           iw_ar_result, iw_sr_result;
  logic [`HBIT_TGT_GP:0] iw_tgt_gp;
  logic                  iw_tgt_gp_we;
  logic [`HBIT_TGT_AR:0] iw_tgt_ar;
  logic                  iw_tgt_ar_we;
  logic [`HBIT_TGT_SR:0] iw_tgt_sr;
  logic                  iw_tgt_sr_we;
  logic                  iw_flush, iw_stall;
  logic                  ow_mem_req, ow_mem_we;
  logic [47:0]           ow_mem_addr;
  logic [23:0]           ow_mem_wdata;
  logic                  iw_mem_ack;
  logic [23:0]           iw_mem_rdata;
  logic [47:0]           ow_pc;
  logic [23:0]           ow_instr;
  logic [`HBIT_OPC:0]    ow_opc;
  logic [23:0]           ow_result;
  logic [47:0]           ow_ar_result, ow_sr_result;
  logic [`HBIT_TGT_GP:0] ow_tgt_gp;
  logic                  ow_tgt_gp_we;
  logic [`HBIT_TGT_AR:0] ow_tgt_ar;
  logic                  ow_tgt_ar_we;
  logic [`HBIT_TGT_SR:0] ow_tgt_sr;
  logic                  ow_tgt_sr_we;
  logic                  ow_stall, ow_fault;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  stg_ma #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
    .iw_mem_rd(iw_mem_rd), .iw_mem_wr(iw_mem_wr), .iw_addr(iw_addr), .iw_result(iw_result),
    .iw_ar_result(iw_ar_result), .iw_sr_result(iw_sr_result),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
    .iw_tgt_ar(iw_tgt_ar), .iw_tgt_ar_we(iw_tgt_ar_we),
    .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
    .iw_flush(iw_flush), .iw_stall(iw_stall),
    .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
    .ow_mem_wdata(ow_mem_wdata), .iw_mem_ack(iw_mem_ack), .iw_mem_rdata(iw_mem_rdata),
    .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc), .ow_result(ow_result),
    .ow_ar_result(ow_ar_result), .ow_sr_result(ow_sr_result),
    .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we),
    .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
    .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
    .ow_stall(ow_stall), .ow_fault(ow_fault)
  );

  always #5 iw_clk = ~iw_clk;

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic clear_inputs();
    iw_pc = '0; iw_instr = '0; iw_opc = '0; iw_mem_rd = 0; iw_mem_wr = 0; iw_addr = '0;
    iw_result = '0; iw_ar_result = '0; iw_sr_result = '0;
    iw_tgt_gp = '0; iw_tgt_gp_we = 0; iw_tgt_ar = '0; iw_tgt_ar_we = 0;
    iw_tgt_sr = '0; iw_tgt_sr_we = 0; iw_flush = 0; iw_stall = 0;
    iw_mem_ack = 0; iw_mem_rdata = '0;
  endtask

  task automatic test_reset();
    iw_rst = 1'b1;
    clear_inputs();
    #2;
    tot_cnt++; if (ow_mem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", ow_mem_req); else pass_cnt++;
    tot_cnt++; if (ow_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", ow_stall); else pass_cnt++;
    tot_cnt++; if (ow_fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", ow_fault); else pass_cnt++;
    tot_cnt++; if (ow_result !== 24'h0) $display("FAIL reset_result got=%h exp=0", ow_result); else pass_cnt++;
    tot_cnt++; if (ow_tgt_gp_we !== 1'b0) $display("FAIL reset_gp_we got=%b exp=0", ow_tgt_gp_we); else pass_cnt++;
    tick();
    iw_rst = 1'b0;
    tick();
  endtask

  task automatic test_pass_through();
    iw_opc = OPC_CSRRD; iw_result = 24'h00A5B6; iw_tgt_gp = 4'd3; iw_tgt_gp_we = 1;
    iw_pc = 48'h1000; iw_instr = 24'h123456; iw_ar_result = 48'hAAAA; iw_sr_result = 48'h5555;
    iw_tgt_ar = 2'd2; iw_tgt_ar_we = 1; iw_tgt_sr = 2'd1; iw_tgt_sr_we = 1;
    #1;
    tot_cnt++; if (ow_stall !== 1'b0) $display("FAIL pt_stall got=%b exp=0", ow_stall); else pass_cnt++;
    tick();
    clear_inputs();
    tot_cnt++; if (ow_result !== 24'h00A5B6) $display("FAIL pt_result got=%h exp=00a5b6", ow_result); else pass_cnt++;
    tot_cnt++; if (ow_tgt_gp !== 4'd3) $display("FAIL pt_tgt_gp got=%0d exp=3", ow_tgt_gp); else pass_cnt++;
    tot_cnt++; if (ow_tgt_gp_we !== 1'b1) $display("FAIL pt_gp_we got=%b exp=1", ow_tgt_gp_we); else pass_cnt++;
    tot_cnt++; if (ow_opc !== OPC_CSRRD) $display("FAIL pt_opc got=%h exp=%h", ow_opc, OPC_CSRRD); else pass_cnt++;
    tot_cnt++; if (ow_pc !== 48'h1000) $display("FAIL pt_pc got=%h exp=1000", ow_pc); else pass_cnt++;
    tot_cnt++; if (ow_instr !== 24'h123456) $display("FAIL pt_instr got=%h exp=123456", ow_instr); else pass_cnt++;
    tot_cnt++; if ({ow_ar_result, ow_sr_result} !== {48'hAAAA, 48'h5555})
      $display("FAIL pt_ar_sr got=%h/%h exp=aaaa/5555", ow_ar_result, ow_sr_result); else pass_cnt++;
    tot_cnt++; if ({ow_tgt_ar, ow_tgt_ar_we, ow_tgt_sr, ow_tgt_sr_we} !== {2'd2, 1'b1, 2'd1, 1'b1})
      $display("FAIL pt_ar_sr_tgt got=%0d/%b/%0d/%b exp=2/1/1/1", ow_tgt_ar, ow_tgt_ar_we, ow_tgt_sr, ow_tgt_sr_we); else pass_cnt++;
    tick();
  endtask

  task automatic test_load();
    int req_n = 0;
    int stall_n = 0;
    iw_mem_rd = 1; iw_addr = 48'h400; iw_tgt_gp = 4'd5; iw_tgt_gp_we = 1; iw_pc = 48'h2000;
    tick();
    clear_inputs();
    tot_cnt++; if (ow_tgt_gp_we !== 1'b0) $display("FAIL ld_bubble_we got=%b exp=0", ow_tgt_gp_we); else pass_cnt++;
    tot_cnt++; if ({ow_mem_addr, ow_mem_we} !== {48'h400, 1'b0})
      $display("FAIL ld_addr_we got=%h/%b exp=400/0", ow_mem_addr, ow_mem_we); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin iw_mem_ack = 1; iw_mem_rdata = 24'h00C0DE; #1; end
      req_n += int'(ow_mem_req);
      stall_n += int'(ow_stall);
      tick();
    end
    clear_inputs();
    tot_cnt++; if (req_n !== 3) $display("FAIL ld_req_cycles got=%0d exp=3", req_n); else pass_cnt++;
    tot_cnt++; if (stall_n !== 2) $display("FAIL ld_stall_cycles got=%0d exp=2", stall_n); else pass_cnt++;
    tot_cnt++; if (ow_result !== 24'h00C0DE) $display("FAIL ld_result got=%h exp=00c0de", ow_result); else pass_cnt++;
    tot_cnt++; if ({ow_tgt_gp, ow_tgt_gp_we} !== {4'd5, 1'b1})
      $display("FAIL ld_tgt got=%0d/%b exp=5/1", ow_tgt_gp, ow_tgt_gp_we); else pass_cnt++;
    tot_cnt++; if (ow_mem_req !== 1'b0) $display("FAIL ld_req_drop got=%b exp=0", ow_mem_req); else pass_cnt++;
    tick();
  endtask

  task automatic test_store();
    iw_mem_wr = 1; iw_addr = 48'h10; iw_result = 24'h00EF12; iw_tgt_gp = 4'd2; iw_tgt_gp_we = 1;
    tick();
    clear_inputs();
    iw_mem_ack = 1;
    #1;
    tot_cnt++; if ({ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata} !== {1'b1, 1'b1, 48'h10, 24'h00EF12})
      $display("FAIL st_bus got=%b/%b/%h/%h exp=1/1/10/00ef12", ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata); else pass_cnt++;
    tot_cnt++; if (ow_stall !== 1'b0) $display("FAIL st_ack_stall got=%b exp=0", ow_stall); else pass_cnt++;
    tick();
    iw_mem_ack = 0;
    tot_cnt++; if ({ow_tgt_gp_we, ow_tgt_ar_we, ow_tgt_sr_we} !== 3'b000)
      $display("FAIL st_we got=%b%b%b exp=000", ow_tgt_gp_we, ow_tgt_ar_we, ow_tgt_sr_we); else pass_cnt++;
    tot_cnt++; if (ow_result !== 24'h00EF12) $display("FAIL st_result got=%h exp=00ef12", ow_result); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    iw_mem_rd = 1; iw_addr = 48'h20; iw_tgt_gp = 4'd1; iw_tgt_gp_we = 1;
    tick();
    clear_inputs();
    iw_mem_ack = 1; iw_mem_rdata = 24'h000111;
    tick();
    clear_inputs();
    iw_mem_rd = 1; iw_addr = 48'h30; iw_tgt_gp = 4'd9; iw_tgt_gp_we = 1;
    #1;
    tot_cnt++; if ({ow_mem_req, ow_stall} !== 2'b00) $display("FAIL b2b_idle got=%b%b exp=00", ow_mem_req, ow_stall); else pass_cnt++;
    tot_cnt++; if (ow_result !== 24'h000111) $display("FAIL b2b_first got=%h exp=000111", ow_result); else pass_cnt++;
    tick();
    clear_inputs();
    tot_cnt++; if ({ow_mem_req, ow_mem_addr} !== {1'b1, 48'h30})
      $display("FAIL b2b_second_req got=%b/%h exp=1/30", ow_mem_req, ow_mem_addr); else pass_cnt++;
    iw_mem_ack = 1; iw_mem_rdata = 24'h000222;
    tick();
    clear_inputs();
    tot_cnt++; if ({ow_result, ow_tgt_gp} !== {24'h000222, 4'd9})
      $display("FAIL b2b_second got=%h/%0d exp=000222/9", ow_result, ow_tgt_gp); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int req_n = 0;
    int fault_n = 0;
    iw_mem_rd = 1; iw_addr = 48'h500; iw_tgt_gp = 4'd6; iw_tgt_gp_we = 1;
    tick();
    clear_inputs();
    while (ow_mem_req === 1'b1 && req_n < 40) begin
      req_n++;
      fault_n += int'(ow_fault);
      tick();
    end
    tot_cnt++; if (req_n !== 16) $display("FAIL to_req_cycles got=%0d exp=16", req_n); else pass_cnt++;
    tot_cnt++; if (fault_n !== 0) $display("FAIL to_early_fault got=%0d exp=0", fault_n); else pass_cnt++;
    tot_cnt++; if ({ow_fault, ow_tgt_gp_we, ow_stall} !== 3'b100)
      $display("FAIL to_end got fault/we/stall=%b%b%b exp=100", ow_fault, ow_tgt_gp_we, ow_stall); else pass_cnt++;
    tick();
    tot_cnt++; if (ow_fault !== 1'b0) $display("FAIL to_pulse got=%b exp=0", ow_fault); else pass_cnt++;
  endtask

  task automatic test_ack_at_timeout();
    iw_mem_rd = 1; iw_addr = 48'h540; iw_tgt_gp = 4'd4; iw_tgt_gp_we = 1;
    tick();
    clear_inputs();
    repeat (15) tick();
    iw_mem_ack = 1; iw_mem_rdata = 24'h0BEEF0;
    #1;
    tot_cnt++; if ({ow_mem_req, ow_stall} !== 2'b10) $display("FAIL tie_req_stall got=%b%b exp=10", ow_mem_req, ow_stall); else pass_cnt++;
    tick();
    clear_inputs();
    tot_cnt++; if ({ow_fault, ow_tgt_gp_we, ow_result} !== {1'b0, 1'b1, 24'h0BEEF0})
      $display("FAIL tie_result got=%b/%b/%h exp=0/1/0beef0", ow_fault, ow_tgt_gp_we, ow_result); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush_wait();
    int req_n = 0;
    iw_mem_rd = 1; iw_addr = 48'h600; iw_tgt_gp = 4'd7; iw_tgt_gp_we = 1;
    tick();
    clear_inputs();
    for (int c = 1; c <= 3; c++) begin
      iw_flush = (c == 1);
      iw_mem_ack = (c == 3);
      iw_mem_rdata = 24'h0ABCDE;
      #1;
      req_n += int'(ow_mem_req);
      tick();
    end
    clear_inputs();
    tot_cnt++; if (req_n !== 3) $display("FAIL fl_req_cycles got=%0d exp=3", req_n); else pass_cnt++;
    tot_cnt++; if ({ow_tgt_gp_we, ow_fault, ow_mem_req} !== 3'b000)
      $display("FAIL fl_end got we/fault/req=%b%b%b exp=000", ow_tgt_gp_we, ow_fault, ow_mem_req); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush_idle_and_stall();
    iw_mem_rd = 1; iw_flush = 1; iw_tgt_gp_we = 1; iw_addr = 48'h700;
    tick();
    clear_inputs();
    tot_cnt++; if ({ow_mem_req, ow_tgt_gp_we} !== 2'b00)
      $display("FAIL fli got req/we=%b%b exp=00", ow_mem_req, ow_tgt_gp_we); else pass_cnt++;
    iw_result = 24'h000111; iw_tgt_gp_we = 1;
    tick();
    iw_result = 24'h222222; iw_stall = 1; iw_mem_rd = 1;
    tick();
    tot_cnt++; if ({ow_result, ow_mem_req} !== {24'h000111, 1'b0})
      $display("FAIL stall_hold got=%h/%b exp=000111/0", ow_result, ow_mem_req); else pass_cnt++;
    clear_inputs();
    iw_mem_ack = 1; iw_mem_rdata = 24'hFFFFFF; iw_result = 24'h000033;
    tick();
    clear_inputs();
    tot_cnt++; if ({ow_result, ow_mem_req} !== {24'h000033, 1'b0})
      $display("FAIL idle_ack got=%h/%b exp=000033/0", ow_result, ow_mem_req); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    iw_mem_rd = 1; iw_addr = 48'h800; iw_pc = 48'h3000; iw_tgt_gp_we = 1;
    tick();
    clear_inputs();
    tot_cnt++; if ({ow_mem_req, ow_pc} !== {1'b1, 48'h3000})
      $display("FAIL rst_pre got=%b/%h exp=1/3000", ow_mem_req, ow_pc); else pass_cnt++;
    #2;
    iw_rst = 1'b1;
    #1;
    tot_cnt++; if ({ow_mem_req, ow_stall, ow_pc, ow_mem_addr} !== {1'b0, 1'b0, 48'h0, 48'h0})
      $display("FAIL rst_mid got=%b/%b/%h/%h exp=0/0/0/0", ow_mem_req, ow_stall, ow_pc, ow_mem_addr); else pass_cnt++;
    #2;
    iw_rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_flush_wait();
    test_flush_idle_and_stall();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
